reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
- Upstream serial master for the 3-wire register bus (enable strobes plus single-bit data in each direction).
- Accepts parallel read/write requests from the control logic over a valid/ready handshake.
- Serialises address and data onto the bus MSB first, deserialises read data returned by the register file, and returns it as a one-cycle response pulse.
- One transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 8, address bits shifted per transaction
- DATA_WIDTH, 8, data bits shifted per transaction
- TURN_CYCLES, 1, idle bus cycles between read address and read data
- GAP_CYCLES, 1, idle bus cycles after every transaction before the next request is accepted

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  master can accept a request
- REQ_WR  in  1  1 = write, 0 = read
- REQ_ADDR  in  ADDR_WIDTH  register address
- REQ_WDATA  in  DATA_WIDTH  write data; ignored for reads
- RSP_VALID  out  1  one-cycle pulse, read data valid
- RSP_RDATA  out  DATA_WIDTH  read data; held until the next RSP_VALID
- BUS_WR_EN  out  1  write strobe to register file
- BUS_RD_EN  out  1  read strobe to register file
- BUS_DIN  out  1  serial data to register file
- BUS_DOUT  in  1  serial data from register file
- BUSY  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset: all outputs are 0 except REQ_READY, which is 1. The FSM is in IDLE, and the counter and shift registers are cleared.
- RSTN asserted mid-transaction aborts immediately: no RSP_VALID is produced, and the strobes and BUS_DIN drop asynchronously.
- Handshake: a request is accepted on the rising edge where REQ_VALID && REQ_READY. REQ_READY = (state == IDLE). Inputs are captured into internal registers at acceptance and are not sampled afterwards.
- FSM states: IDLE, CMD, ADDR, WDATA, TURN, RDATA, RSP, GAP.
- IDLE -> CMD on acceptance.
- CMD (1 cycle): BUS_WR_EN=1 for a write, BUS_RD_EN=1 for a read, BUS_DIN=0. Next state is ADDR.
- ADDR (ADDR_WIDTH cycles): BUS_DIN = address bit, MSB first; the first ADDR cycle carries bit ADDR_WIDTH-1. Next state is WDATA for a write, TURN for a read.
- WDATA (DATA_WIDTH cycles): BUS_DIN = data bit, MSB first. Next state is GAP.
- TURN (TURN_CYCLES cycles): BUS_DIN=0. Next state is RDATA.
- RDATA (DATA_WIDTH cycles): BUS_DOUT is sampled at the rising edge ending each cycle and shifted into the LSB; the first sampled bit ends as the MSB. Next state is RSP.
- RSP (1 cycle): RSP_VALID=1 and RSP_RDATA = assembled byte, registered on RSP entry. Next state is GAP.
- GAP (GAP_CYCLES cycles, BUS_DIN=0) -> IDLE. If GAP_CYCLES=0, the transition goes directly to IDLE.
- Strobes are asserted only in CMD. BUS_DIN is 0 outside ADDR/WDATA.
- Latency with defaults, acceptance at edge T (state CMD during T..T+1):
  - Write: BUS_WR_EN high in cycle 1 after acceptance, address in cycles 2-9, data in cycles 10-17, GAP in cycle 18. REQ_READY rises at cycle 19; back-to-back throughput is 1 write per 19 cycles.
  - Read: CMD in cycle 1, address in cycles 2-9, TURN in cycle 10, RDATA in cycles 11-18, RSP_VALID in cycle 19, GAP in cycle 20. REQ_READY rises at cycle 21.
- Bit counter: log2 of max(ADDR_WIDTH, DATA_WIDTH, TURN_CYCLES, GAP_CYCLES), rounded up, plus 1 bit. It reloads on each state entry and counts down to 0, and the state exits when it reaches 0. There is no wrap-around.
- REQ_VALID while busy is ignored. The requester holds the request, and no request is dropped or duplicated.
- A write or read to an unmapped address is performed normally. A read of an unmapped address returns whatever BUS_DOUT carries; the register file drives 0.

Decomposition:
- Package reg_bus_pkg holds:
  - state enum reg_bus_state_t;
  - widths ADDR_WIDTH/DATA_WIDTH;
  - register map constants: REG0..REG3 = 8'h34, 8'h78, 8'hA1, 8'h06 (read/write), REG4 = 8'h55 (read-only, value 8'h33).
- One sub-module, reg_bus_shifter: a combined parallel-load PISO/SIPO with load, shift-out and shift-in controls, shared by the address, write-data and read-data paths.
- FSM and counter stay in the top.

Test Plan:
- Reset: assert RSTN=0 mid-stream -> REQ_READY=1, BUS_* = 0, RSP_VALID never pulses. Release and check the idle bus for 5 cycles.
- Single write, addr 8'h34 data 8'hA5:
  - BUS_WR_EN pulse 1 cycle after acceptance;
  - BUS_DIN sequence 0,0,1,1,0,1,0,0 then 1,0,1,0,0,1,0,1;
  - REQ_READY returns at cycle 19.
- Read of REG4 (8'h55) against a register-file model -> RSP_VALID at cycle 19 with RSP_RDATA=8'h33. BUS_RD_EN high exactly 1 cycle.
- Write then read-back: write 8'hC3 to 8'hA1, then read 8'hA1 -> RSP_RDATA=8'hC3. REQ_VALID held high continuously, so the two transactions are accepted exactly once each.
- Back-to-back: 4 writes with REQ_VALID held high -> acceptances exactly 19 cycles apart, with no strobe overlap.
- Mid-op reset: RSTN low during RDATA bit 4 -> no RSP_VALID. A subsequent read of 8'h55 returns 8'h33.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the 3-wire register bus master and its register map.
package reg_bus_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        TURN,
        RDATA,
        RSP,
        GAP
    } reg_bus_state_t;

    localparam logic [ADDR_WIDTH-1:0] REG0_ADDR  = 8'h34;
    localparam logic [ADDR_WIDTH-1:0] REG1_ADDR  = 8'h78;
    localparam logic [ADDR_WIDTH-1:0] REG2_ADDR  = 8'hA1;
    localparam logic [ADDR_WIDTH-1:0] REG3_ADDR  = 8'h06;
    localparam logic [ADDR_WIDTH-1:0] REG4_ADDR  = 8'h55;
    localparam logic [DATA_WIDTH-1:0] REG4_VALUE = 8'h33;

endpackage

// File: rtl/reg_bus_master_if.sv
// Request/response handshake and serial bus wires of the register bus master.
interface reg_bus_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) ();

    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic                  REQ_WR;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic [DATA_WIDTH-1:0] REQ_WDATA;
    logic                  RSP_VALID;
    logic [DATA_WIDTH-1:0] RSP_RDATA;
    logic                  BUS_WR_EN;
    logic                  BUS_RD_EN;
    logic                  BUS_DIN;
    logic                  BUS_DOUT;
    logic                  BUSY;

    modport master (
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, BUS_DOUT,
        output REQ_READY, RSP_VALID, RSP_RDATA, BUS_WR_EN, BUS_RD_EN, BUS_DIN, BUSY
    );

    modport slave (
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, BUS_DOUT,
        input  REQ_READY, RSP_VALID, RSP_RDATA, BUS_WR_EN, BUS_RD_EN, BUS_DIN, BUSY
    );

endinterface

// File: rtl/reg_bus_shifter.sv
// Parallel-load shift register: MSB-first serial out, serial in at the LSB.
module reg_bus_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_out_i,
    input  logic             shift_in_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = load_val_i;
        end else if (shift_out_i) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end else if (shift_in_i) begin
            shift_d = {shift_q[WIDTH-2:0], sin_i};
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign sout_o = shift_q[WIDTH-1];
    assign next_o = shift_d;

endmodule

// File: rtl/reg_bus_master.sv
// Serial master for the 3-wire register bus: one read or write in flight at a time.
//   state | meaning
//   IDLE  | ready for a request
//   CMD   | strobe cycle (WR_EN or RD_EN)
//   ADDR  | address bits out, MSB first
//   WDATA | write data bits out, MSB first
//   TURN  | idle turnaround before read data
//   RDATA | read data bits sampled from BUS_DOUT
//   RSP   | one-cycle response pulse
//   GAP   | idle cycles before the next request
module reg_bus_master #(
    parameter int ADDR_WIDTH  = reg_bus_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = reg_bus_pkg::DATA_WIDTH,
    parameter int TURN_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    reg_bus_master_if.master bus
);
    import reg_bus_pkg::*;

    localparam int SHIFT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_TG  = (TURN_CYCLES > GAP_CYCLES) ? TURN_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (SHIFT_W > MAX_TG) ? SHIFT_W : MAX_TG;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    reg_bus_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_load;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  accept;
    logic                  cnt_zero;
    logic                  sh_load, sh_out, sh_in, sh_sout;
    logic [SHIFT_W-1:0]    sh_load_val, sh_next;

    assign accept   = bus.REQ_VALID && (state_q == IDLE);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.REQ_WR;
                wdata_q <= bus.REQ_WDATA;
            end
            if (state_q == RDATA && state_d == RSP) begin
                rsp_rdata_q <= sh_next[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept)   state_d = CMD;
            CMD:                 state_d = ADDR;
            ADDR:  if (cnt_zero) state_d = wr_q ? WDATA : TURN;
            WDATA: if (cnt_zero) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            TURN:  if (cnt_zero) state_d = RDATA;
            RDATA: if (cnt_zero) state_d = RSP;
            RSP:                 state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (cnt_zero) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Counter holds remaining cycles minus one, reloaded on every state change.
    always_comb begin
        cnt_load = '0;
        case (state_d)
            ADDR:         cnt_load = CNT_W'(ADDR_WIDTH - 1);
            WDATA, RDATA: cnt_load = CNT_W'(DATA_WIDTH - 1);
            TURN:         cnt_load = CNT_W'(TURN_CYCLES - 1);
            GAP:          cnt_load = CNT_W'(GAP_CYCLES - 1);
            default:      cnt_load = '0;
        endcase
        if (state_d != state_q) begin
            cnt_d = cnt_load;
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Address is loaded at acceptance; write data replaces it on the last address cycle.
    assign sh_load     = accept || (state_q == ADDR && cnt_zero && wr_q);
    assign sh_load_val = accept ? (SHIFT_W'(bus.REQ_ADDR) << (SHIFT_W - ADDR_WIDTH))
                                : (SHIFT_W'(wdata_q) << (SHIFT_W - DATA_WIDTH));
    assign sh_out      = (state_q == ADDR) || (state_q == WDATA);
    assign sh_in       = (state_q == RDATA);

    reg_bus_shifter #(
        .WIDTH (SHIFT_W)
    ) u_shifter (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .load_i      (sh_load),
        .load_val_i  (sh_load_val),
        .shift_out_i (sh_out),
        .shift_in_i  (sh_in),
        .sin_i       (bus.BUS_DOUT),
        .sout_o      (sh_sout),
        .next_o      (sh_next)
    );

    always_comb begin
        bus.REQ_READY = (state_q == IDLE);
        bus.BUSY      = (state_q != IDLE);
        bus.BUS_WR_EN = (state_q == CMD) && wr_q;
        bus.BUS_RD_EN = (state_q == CMD) && !wr_q;
        bus.BUS_DIN   = sh_out ? sh_sout : 1'b0;
        bus.RSP_VALID = (state_q == RSP);
        bus.RSP_RDATA = rsp_rdata_q;
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a behavioural register-file slave on the serial bus.
module tb_reg_bus_master;

    logic CLK;
    logic RSTN;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cnt = 0;
    int   rsp_cnt = 0;

    reg_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    reg_bus_master dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RSTN && bus.REQ_VALID && bus.REQ_READY) acc_cnt <= acc_cnt + 1;
        if (bus.RSP_VALID) rsp_cnt <= rsp_cnt + 1;
    end

    // Register-file model: samples mid-cycle, drives read bits so they settle before the master samples.
    logic [7:0] r0 = 8'h00, r1 = 8'h00, r2 = 8'h00, r3 = 8'h00;
    logic [7:0] s_addr, s_data;
    logic       s_wr;
    int         ph = 0;

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        case (a)
            8'h34:   return r0;
            8'h78:   return r1;
            8'hA1:   return r2;
            8'h06:   return r3;
            8'h55:   return 8'h33;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (!RSTN) begin
            ph = 0;
            bus.BUS_DOUT = 1'b0;
        end else if (ph == 0) begin
            if (bus.BUS_WR_EN || bus.BUS_RD_EN) begin
                ph = 1;
                s_wr = bus.BUS_WR_EN;
                s_addr = 8'h00;
            end
        end else if (ph <= 8) begin
            s_addr = {s_addr[6:0], bus.BUS_DIN};
            ph++;
        end else if (s_wr) begin
            s_data = {s_data[6:0], bus.BUS_DIN};
            if (ph == 16) begin
                case (s_addr)
                    8'h34: r0 = s_data;
                    8'h78: r1 = s_data;
                    8'hA1: r2 = s_data;
                    8'h06: r3 = s_data;
                    default: ;
                endcase
                ph = 0;
            end else begin
                ph++;
            end
        end else if (ph == 9) begin
            s_data = mem_rd(s_addr);
            ph++;
        end else if (ph <= 17) begin
            bus.BUS_DOUT = s_data[7];
            s_data = {s_data[6:0], 1'b0};
            ph++;
        end else begin
            bus.BUS_DOUT = 1'b0;
            ph = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // {WR_EN, RD_EN, DIN, RSP_VALID, REQ_READY, BUSY}
    function automatic logic [31:0] vec();
        return {26'd0, bus.BUS_WR_EN, bus.BUS_RD_EN, bus.BUS_DIN,
                bus.RSP_VALID, bus.REQ_READY, bus.BUSY};
    endfunction

    task automatic accept(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output int acc_cyc);
        int n = 0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = wr;
        bus.REQ_ADDR  = a;
        bus.REQ_WDATA = d;
        while (!bus.REQ_READY && n < 60) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, bus.REQ_READY}, 32'd1);
        @(posedge CLK);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic run_write(input logic [7:0] a, input logic [7:0] d, input logic keep,
                             output int acc_cyc);
        logic [15:0]  bits;
        logic [31:0]  e;
        bits = {a, d};
        accept(1'b1, a, d, acc_cyc);
        if (!keep) bus.REQ_VALID = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) tick();
            if (k == 1)       e = 32'b100001;
            else if (k <= 17) e = {29'd0, bits[17-k], 2'b01} ;
            else if (k == 18) e = 32'b000001;
            else              e = 32'b000010;
            if (k >= 2 && k <= 17) e = {26'd0, 2'b00, bits[17-k], 3'b001};
            chk($sformatf("wr_%02h_c%0d", a, k), vec(), e);
        end
    endtask

    task automatic run_read(input logic [7:0] a, input logic [7:0] exp_d, input logic keep,
                            output int acc_cyc);
        logic [31:0] e;
        accept(1'b0, a, 8'h00, acc_cyc);
        if (!keep) bus.REQ_VALID = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k > 1) tick();
            if (k == 1)      e = 32'b010001;
            else if (k <= 9) e = {26'd0, 2'b00, a[9-k], 3'b001};
            else if (k == 19) e = 32'b000101;
            else if (k <= 20) e = 32'b000001;
            else             e = 32'b000010;
            chk($sformatf("rd_%02h_c%0d", a, k), vec(), e);
            if (k == 19 || k == 21)
                chk($sformatf("rd_%02h_data_c%0d", a, k), {24'd0, bus.RSP_RDATA}, {24'd0, exp_d});
        end
    endtask

    initial begin
        int t0, t1, t2, t3, a0, r0c;
        RSTN          = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WR    = 1'b0;
        bus.REQ_ADDR  = 8'h00;
        bus.REQ_WDATA = 8'h00;
        #1;
        chk("reset_outputs", vec(), 32'b000010);
        chk("reset_rdata", {24'd0, bus.RSP_RDATA}, 32'd0);
        tick();
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle_c%0d", i), vec(), 32'b000010);
        end

        run_write(8'h34, 8'hA5, 1'b0, t0);
        run_read(8'h55, 8'h33, 1'b0, t0);

        a0 = acc_cnt;
        run_write(8'hA1, 8'hC3, 1'b1, t0);
        run_read(8'hA1, 8'hC3, 1'b0, t1);
        chk("wr_rd_spacing", t1 - t0, 32'd19);
        tick();
        tick();
        chk("wr_rd_accepts", acc_cnt - a0, 32'd2);

        a0 = acc_cnt;
        run_write(8'h34, 8'h11, 1'b1, t0);
        run_write(8'h78, 8'h22, 1'b1, t1);
        run_write(8'h06, 8'h44, 1'b1, t2);
        run_write(8'hA1, 8'h88, 1'b0, t3);
        chk("b2b_gap1", t1 - t0, 32'd19);
        chk("b2b_gap2", t2 - t1, 32'd19);
        chk("b2b_gap3", t3 - t2, 32'd19);
        tick();
        tick();
        chk("b2b_accepts", acc_cnt - a0, 32'd4);
        run_read(8'h06, 8'h44, 1'b0, t0);
        run_read(8'h78, 8'h22, 1'b0, t0);

        r0c = rsp_cnt;
        accept(1'b0, 8'h55, 8'h00, t0);
        bus.REQ_VALID = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        RSTN = 1'b0;
        #1;
        chk("midrst_outputs", vec(), 32'b000010);
        chk("midrst_rdata", {24'd0, bus.RSP_RDATA}, 32'd0);
        tick();
        tick();
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("midrst_no_rsp", rsp_cnt - r0c, 32'd0);
        chk("midrst_idle", vec(), 32'b000010);
        run_read(8'h55, 8'h33, 1'b0, t0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
